// File: rtl/imem_loader.sv
// imem_loader: boot-time programmer for the instruction memory write port.
// Parses a UART byte stream framed as SYNC, 16-bit little-endian word count
// N and 4*N payload bytes. Each payload word is packed little-endian and
// written with a one-cycle w_en strobe. The CPU is held in reset until the
// image is complete.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// byte equal to the XOR of all payload bytes before the image is accepted.
module imem_loader #(
    parameter int unsigned INST_MEMORY_SIZE = 16384,
    parameter int unsigned ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE),
    parameter logic [7:0]  SYNC_BYTE        = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES   = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [31:0]           write_data,
    output logic                  w_en,
    output logic                  cpu_rst_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned MAX_WORDS = INST_MEMORY_SIZE / 4;
    localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q;
    logic [15:0]           len_q;
    logic [1:0]            byte_cnt_q;
    logic [23:0]           pack_q;
    logic [12:0]           word_cnt_q;
    logic [TMO_W-1:0]      tmo_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  wen_q;
    logic                  hold_q;
    logic                  done_q;
    logic                  err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            xor_q;
`endif

    logic [15:0]           len_d;
    logic                  last_word;
    logic                  tmo_expire;

    assign len_d      = {rx_data, len_q[7:0]};
    assign last_word  = ((16'(word_cnt_q) + 16'd1) == len_q);
    assign tmo_expire = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign busy = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
    assign busy = (state_q == S_LEN) || (state_q == S_DATA);
`endif

    assign write_addr   = addr_q;
    assign write_data   = wdata_q;
    assign w_en         = wen_q;
    assign cpu_rst_hold = hold_q;
    assign done         = done_q;
    assign error        = err_q;

    // Frame parser, word packer, write strobe and inactivity timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            pack_q     <= '0;
            word_cnt_q <= '0;
            tmo_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            wen_q <= 1'b0;
            // The strobe cycle retires the word regardless of state, so a
            // transition decided on the final byte never loses the advance.
            if (wen_q) begin
                addr_q     <= addr_q + ADDR_WIDTH'(4);
                word_cnt_q <= word_cnt_q + 13'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state_q    <= S_LEN;
                        word_cnt_q <= '0;
                        addr_q     <= '0;
                        byte_cnt_q <= '0;
                        tmo_q      <= '0;
                    end
                end

                S_LEN: begin
                    if (rx_valid) begin
                        if (byte_cnt_q == 2'd0) begin
                            len_q[7:0] <= rx_data;
                            byte_cnt_q <= 2'd1;
                        end else begin
                            byte_cnt_q <= '0;
                            len_q      <= len_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            xor_q      <= '0;
`endif
                            if (len_d == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_q <= S_CSUM;
`else
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                hold_q  <= 1'b0;
`endif
                            end else if (32'(len_d) > MAX_WORDS) begin
                                state_q <= S_ERROR;
                                err_q   <= 1'b1;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (rx_valid) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q      <= xor_q ^ rx_data;
`endif
                        // Bytes 0..2 collect in pack_q so write_data stays
                        // stable while a previous word is being strobed.
                        case (byte_cnt_q)
                            2'd0: pack_q[7:0]   <= rx_data;
                            2'd1: pack_q[15:8]  <= rx_data;
                            2'd2: pack_q[23:16] <= rx_data;
                            default: begin
                                wdata_q <= {rx_data, pack_q};
                                wen_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                                // Leave early so a checksum byte arriving
                                // during the final strobe is not missed.
                                if (last_word) begin
                                    state_q <= S_CSUM;
                                end
`endif
                            end
                        endcase
                    end
`ifndef IMEM_LOADER_CHECKSUM_EN
                    if (wen_q && last_word) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                    end
`endif
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == xor_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif

                S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        hold_q  <= 1'b1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase

            if (busy) begin
                if (rx_valid) begin
                    tmo_q <= '0;
                end else if (tmo_expire) begin
                    state_q <= S_ERROR;
                    err_q   <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors, hand-written corner
// sequences and randomized frames checked against a frame-level model.
module tb_imem_loader;

    localparam int unsigned MEM  = 16384;
    localparam int unsigned AW   = 14;
    localparam int unsigned TMO  = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          start;
    logic [AW-1:0] write_addr;
    logic [31:0]   write_data;
    logic          w_en;
    logic          cpu_rst_hold;
    logic          busy;
    logic          done;
    logic          error;

    imem_loader #(
        .INST_MEMORY_SIZE(MEM),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .start(start),
        .write_addr(write_addr),
        .write_data(write_data),
        .w_en(w_en),
        .cpu_rst_hold(cpu_rst_hold),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    // Write monitor
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    int          last_wen_cyc;
    int          first_done_cyc;
    int          wen_multi;
    bit          prev_wen = 1'b0;

    always @(negedge clk) begin
        if (w_en) begin
            got_a.push_back(32'(write_addr));
            got_d.push_back(write_data);
            last_wen_cyc = cyc;
            if (prev_wen) wen_multi++;
        end
        prev_wen = w_en;
        if (done && first_done_cyc < 0) first_done_cyc = cyc;
    end

    // Expected results
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    bit          exp_done;
    bit          exp_err;

    typedef struct {
        logic [15:0][7:0] b;
        int unsigned      n;
        bit               b2b;
        int unsigned      nw;
        logic [1:0][31:0] wa;
        logic [1:0][31:0] wd;
        bit               ed;
        bit               ee;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        got_a.delete();
        got_d.delete();
        last_wen_cyc   = -1;
        first_done_cyc = -1;
        wen_multi      = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit rnd_gap);
        foreach (s[i]) begin
            @(negedge clk);
            rx_data  = s[i];
            rx_valid = 1'b1;
            if (rnd_gap) begin
                int unsigned g = $urandom_range(0, 3);
                if (g > 0) begin
                    @(negedge clk);
                    rx_valid = 1'b0;
                    rx_data  = 8'($urandom);
                    repeat (g - 1) @(negedge clk);
                end
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int bound);
        int k = 0;
        while (!(done || error) && k < bound) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".finished"}, 32'(done | error), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Frame-level reference: find sync, read N, slice payload into words.
    task automatic model(input logic [7:0] s[$]);
        int unsigned i = 0;
        int unsigned n;
        logic [7:0]  x = 8'h00;
        exp_a.delete();
        exp_d.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        while (i < s.size() && s[i] != 8'hA5) i++;
        i++;
        n = 32'({s[i+1], s[i]});
        i += 2;
        if (n > MEM / 4) begin
            exp_err = 1'b1;
            return;
        end
        for (int unsigned w = 0; w < n; w++) begin
            exp_a.push_back(4 * w);
            exp_d.push_back({s[i+3], s[i+2], s[i+1], s[i]});
            x = x ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
            i += 4;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (s[i] == x) exp_done = 1'b1;
        else exp_err = 1'b1;
`else
        exp_done = 1'b1;
`endif
    endtask

    task automatic compare_result(input string tag);
        check({tag, ".nwrites"}, 32'(got_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            check($sformatf("%s.addr%0d", tag, i), got_a[i], exp_a[i]);
            check($sformatf("%s.data%0d", tag, i), got_d[i], exp_d[i]);
        end
        check({tag, ".done"}, 32'(done), 32'(exp_done));
        check({tag, ".error"}, 32'(error), 32'(exp_err));
        check({tag, ".hold"}, 32'(cpu_rst_hold), 32'(!exp_done));
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".wen_single"}, 32'(wen_multi), 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (exp_done && exp_a.size() > 0)
            check({tag, ".done_lat"}, 32'(first_done_cyc - last_wen_cyc), 32'd1);
`endif
    endtask

    task automatic addv(input logic [7:0] s[$], input bit b2b, input int unsigned nw,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic [31:0] a1, input logic [31:0] d1,
                        input bit ed, input bit ee);
        vec_t v;
        v.b   = '0;
        v.n   = s.size();
        foreach (s[i]) v.b[i] = s[i];
        v.b2b = b2b;
        v.nw  = nw;
        v.wa[0] = a0; v.wd[0] = d0;
        v.wa[1] = a1; v.wd[1] = d1;
        v.ed  = ed;
        v.ee  = ee;
        vt.push_back(v);
    endtask

    initial begin
        logic [7:0]  s[$];
        logic [7:0]  b;
        logic [7:0]  x;
        int unsigned n;

        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        start    = 1'b0;
        clear_mon();

        // Reset state
        @(negedge clk);
        check("rst.w_en", 32'(w_en), 32'd0);
        check("rst.addr", 32'(write_addr), 32'd0);
        check("rst.data", write_data, 32'd0);
        check("rst.hold", 32'(cpu_rst_hold), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.error", 32'(error), 32'd0);
        rst = 1'b0;

        // Vector table
        s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h88);
`endif
        addv(s, 1'b0, 2, 32'h0, 32'h44332211, 32'h4, 32'h88776655, 1'b1, 1'b0);
        addv(s, 1'b1, 2, 32'h0, 32'h44332211, 32'h4, 32'h88776655, 1'b1, 1'b0);
        s = '{8'hA5, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        addv(s, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        s = '{8'hA5, 8'h01, 8'h10};
        addv(s, 1'b1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        s = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h22);
`endif
        addv(s, 1'b1, 1, 32'h0, 32'hEFBEADDE, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        s = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        addv(s, 1'b1, 1, 32'h0, 32'h08040201, 32'h0, 32'h0, 1'b1, 1'b0);
        s = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
        addv(s, 1'b1, 1, 32'h0, 32'h08040201, 32'h0, 32'h0, 1'b0, 1'b1);
`endif

        foreach (vt[k]) begin
            do_reset();
            clear_mon();
            s.delete();
            for (int unsigned i = 0; i < vt[k].n; i++) s.push_back(vt[k].b[i]);
            exp_a.delete();
            exp_d.delete();
            for (int unsigned w = 0; w < vt[k].nw; w++) begin
                exp_a.push_back(vt[k].wa[w]);
                exp_d.push_back(vt[k].wd[w]);
            end
            exp_done = vt[k].ed;
            exp_err  = vt[k].ee;
            send_stream(s, !vt[k].b2b);
            wait_end($sformatf("vec%0d", k), 200);
            compare_result($sformatf("vec%0d", k));
        end

        // Oversize, re-arm with start, start ignored mid-frame
        do_reset();
        clear_mon();
        s = '{8'hA5, 8'h01, 8'h10};
        send_stream(s, 1'b0);
        wait_end("ovr", 50);
        check("ovr.error", 32'(error), 32'd1);
        check("ovr.hold", 32'(cpu_rst_hold), 32'd1);
        check("ovr.nwrites", 32'(got_a.size()), 32'd0);
        pulse_start();
        check("ovr.rearm.error", 32'(error), 32'd0);
        check("ovr.rearm.done", 32'(done), 32'd0);
        check("ovr.rearm.hold", 32'(cpu_rst_hold), 32'd1);
        check("ovr.rearm.busy", 32'(busy), 32'd0);
        s = '{8'hA5};
        send_stream(s, 1'b0);
        pulse_start();
        check("midstart.busy", 32'(busy), 32'd1);
        s = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h22);
`endif
        send_stream(s, 1'b0);
        wait_end("midstart", 50);
        exp_a = '{32'h0};
        exp_d = '{32'hEFBEADDE};
        exp_done = 1'b1;
        exp_err  = 1'b0;
        compare_result("midstart");

        // Timeout: error exactly TMO edges after the BB byte is sampled
        do_reset();
        clear_mon();
        s = '{8'hA5, 8'h01, 8'h00, 8'hAA};
        send_stream(s, 1'b0);
        @(negedge clk);
        rx_data  = 8'hBB;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("tmo.early_error", 32'(error), 32'd0);
        check("tmo.early_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("tmo.error", 32'(error), 32'd1);
        check("tmo.hold", 32'(cpu_rst_hold), 32'd1);
        check("tmo.busy", 32'(busy), 32'd0);
        check("tmo.nwrites", 32'(got_a.size()), 32'd0);

        // Reset asserted during a write strobe
        do_reset();
        clear_mon();
        s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        send_stream(s, 1'b0);
        @(negedge clk);
        rx_data  = 8'h44;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        check("mrst.pre_wen", 32'(w_en), 32'd1);
        check("mrst.pre_data", write_data, 32'h44332211);
        #2 rst = 1'b1;
        #1;
        check("mrst.w_en", 32'(w_en), 32'd0);
        check("mrst.addr", 32'(write_addr), 32'd0);
        check("mrst.data", write_data, 32'd0);
        check("mrst.hold", 32'(cpu_rst_hold), 32'd1);
        check("mrst.busy", 32'(busy), 32'd0);
        check("mrst.done", 32'(done), 32'd0);
        check("mrst.error", 32'(error), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Largest legal image, N = MEM/4
        clear_mon();
        n = MEM / 4;
        s = '{8'hA5, 8'(n), 8'(n >> 8)};
        x = 8'h00;
        for (int unsigned i = 0; i < 4 * n; i++) begin
            b = 8'(i) ^ 8'(i >> 8);
            s.push_back(b);
            x ^= b;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(x);
`endif
        model(s);
        send_stream(s, 1'b0);
        wait_end("max", 200);
        compare_result("max");

        // Randomized frames, re-armed with start
        for (int t = 0; t < 30; t++) begin
            s.delete();
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                s.push_back(b);
            end
            s.push_back(8'hA5);
            if ($urandom_range(0, 7) == 0) n = $urandom_range(MEM / 4 + 1, 65535);
            else n = $urandom_range(0, 4);
            s.push_back(8'(n));
            s.push_back(8'(n >> 8));
            if (n <= MEM / 4) begin
                x = 8'h00;
                for (int unsigned i = 0; i < 4 * n; i++) begin
                    b = 8'($urandom);
                    s.push_back(b);
                    x ^= b;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                if ($urandom_range(0, 3) == 0) x ^= 8'h01 << $urandom_range(0, 7);
                s.push_back(x);
`endif
            end
            model(s);
            pulse_start();
            check($sformatf("rnd%0d.rearm_hold", t), 32'(cpu_rst_hold), 32'd1);
            clear_mon();
            send_stream(s, $urandom_range(0, 1) == 1);
            wait_end($sformatf("rnd%0d", t), 200);
            compare_result($sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time programmer that drives the instruction memory's write-only programming port.
- Consumes a byte stream from the UART receiver, parses a framed image (sync, length, payload), packs bytes little-endian into 32-bit words and issues one write per word.
- Holds the CPU in reset while loading and releases it once the image is complete.

Parameters:
- INST_MEMORY_SIZE, 16384, instruction memory size in bytes; must match the memory instance.
- ADDR_WIDTH, $clog2(INST_MEMORY_SIZE), byte-address width of the programming port.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, maximum idle gap between bytes inside a frame before an error is raised.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle; may assert on consecutive cycles.
- start  input  1  re-arm pulse, honoured only in DONE or ERROR.
- write_addr  output  ADDR_WIDTH  byte address to the memory programming port, always a multiple of 4.
- write_data  output  32  word to write.
- w_en  output  1  one-cycle write strobe.
- cpu_rst_hold  output  1  high keeps the core in reset.
- busy  output  1  high in LEN, DATA or CSUM.
- done  output  1  image loaded successfully.
- error  output  1  frame rejected.

Behaviour:
- Reset values: state IDLE; cpu_rst_hold=1; w_en=0; write_addr=0; write_data=0; done=0; error=0; byte counter=0; word counter=0; timeout counter=0.
- States: IDLE, LEN, DATA, CSUM, DONE, ERROR.
- IDLE: each rx_valid byte is compared against SYNC_BYTE. Non-matching bytes are discarded. A match moves to LEN and clears the word counter and write_addr.
- LEN: two bytes, little-endian, form the 16-bit word count N.
  - N==0 goes to DONE (or to CSUM when the optional feature is enabled).
  - N > INST_MEMORY_SIZE/4 goes to ERROR.
  - Otherwise go to DATA.
- DATA: bytes fill write_data little-endian; byte 0 lands in bits [7:0].
  - On the cycle after the 4th byte is sampled: w_en=1 for exactly one cycle, with write_addr = 4*word_index and write_data stable.
  - write_addr advances by 4 on the cycle after the strobe.
  - A byte arriving during the strobe cycle is accepted into the next word; packing must not corrupt the word being written.
  - After the Nth write, go to DONE (or CSUM).
- CSUM: present only when the optional feature is compiled in (see below).
- DONE: done=1 and cpu_rst_hold=0, both asserted the cycle after entering the state, i.e. one cycle after the final w_en.
- ERROR: error=1 and cpu_rst_hold stays 1. Memory contents are whatever was written before the fault.
- In DONE and ERROR, rx_valid is ignored.
- start in DONE or ERROR returns to IDLE, clears done and error, and asserts cpu_rst_hold in the next cycle. start in any other state is ignored.
- Timeout: in LEN, DATA and CSUM the counter resets on every rx_valid and increments otherwise. On reaching TIMEOUT_CYCLES, go to ERROR. The counter is inactive in IDLE, DONE and ERROR.
- Reset mid-frame immediately aborts the frame: all outputs return to their reset values and w_en drops at once.
- The word counter is 13 bits wide, which covers N up to 4096. The comparison against N uses a 16-bit zero-extended compare.

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN defined:
  - A running XOR of all payload bytes is kept.
  - After the last word (or directly after LEN when N==0), state CSUM takes one byte.
  - If the byte equals the XOR, go to DONE; otherwise go to ERROR. Words already written remain in memory.
- Undefined: CSUM state and XOR logic are absent; DATA goes directly to DONE.

Test Plan:
- Two-word load: A5 02 00 11 22 33 44 55 66 77 88 -> w_en pulses with (addr 0x000, 0x44332211) and (0x004, 0x88776655); done=1 and cpu_rst_hold=0 one cycle after the second pulse.
- Empty image: A5 00 00 -> no w_en; done=1 (checksum build: append 00 -> done=1).
- Oversize: A5 01 10 (N=4097) -> error=1, no w_en, cpu_rst_hold=1; then start -> IDLE with error=0.
- Leading garbage plus back-to-back bytes: 00 FF 3C A5 01 00 DE AD BE EF, with rx_valid held high on consecutive cycles -> single write (0x000, 0xEFBEADDE); done=1.
- Timeout, with TIMEOUT_CYCLES=100: A5 01 00 AA BB then silence -> error exactly 100 cycles after the BB strobe, no w_en; rst asserted mid-frame in a second run -> all outputs at reset values.
- Checksum (macro defined): A5 01 00 01 02 04 08 0F -> done; same frame ending 0E -> error after one w_en (0x000, 0x08040201).
